// File: rtl/rob_pkg.sv
// Shared constants and types for the ROB retirement path.
//
// ARF_SIZE / ARF_WIDTH : architectural register file size and index width
// PRF_WIDTH            : physical register tag width
// ROB_WIDTH            : index width of the 32-entry reorder buffer
// commit_state_t       : retirement sequencer state (RUN / RESTORE)
package rob_pkg;

  localparam int ARF_SIZE  = 32;
  localparam int ARF_WIDTH = 5;
  localparam int PRF_WIDTH = 6;
  localparam int ROB_WIDTH = 5;

  typedef enum logic {
    RUN     = 1'b0,
    RESTORE = 1'b1
  } commit_state_t;

endpackage : rob_pkg

// File: rtl/rrat_table.sv
// Retirement register alias table: the committed architectural-to-physical
// mapping. Resets to identity (entry i holds tag i).
//
// Ports:
//   clock, reset_n          : clock, asynchronous active-low reset
//   rd_a_idx / rd_a_data    : combinational read (old mapping for the free list)
//   rd_b_idx / rd_b_data    : combinational read (map-table replay)
//   we, wr_idx, wr_data     : write port, takes effect at the rising edge
//
// A read and a write of the same entry in one cycle returns the old value.
module rrat_table #(
  parameter int DEPTH  = 32,
  parameter int IDX_W  = 5,
  parameter int DATA_W = 6
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [IDX_W-1:0]  rd_a_idx,
  output logic [DATA_W-1:0] rd_a_data,
  input  logic [IDX_W-1:0]  rd_b_idx,
  output logic [DATA_W-1:0] rd_b_data,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] map [DEPTH];

  // NOTE: this array is architectural state that must come out of reset as
  // identity, so it is built from resettable flops rather than a RAM macro.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        map[i] <= DATA_W'(i);
      end
    end else if (we) begin
      map[wr_idx] <= wr_data;
    end
  end

  assign rd_a_data = map[rd_a_idx];
  assign rd_b_data = map[rd_b_idx];

endmodule : rrat_table

// File: rtl/rob_commit_ctrl.sv
// ROB retirement sequencer. Pops the ROB head when complete, updates the
// RRAT and frees the superseded physical tag, holds stores until the LSQ
// accepts them, and on a mispredicted branch at the head squashes for one
// cycle and then replays all RRAT entries into the front-end map table.
//
// Optional build macro: COMMIT_STATS_EN adds retired_count and
// mispredict_count (32-bit, wrapping) output ports.
//
// Inputs : rob_head_* (head entry status/fields), st_commit_ready (LSQ)
// Outputs: rob_retire, free_valid/free_prf, st_commit_valid, squash,
//          redirect_pc, restore_valid/restore_arf/restore_prf, dispatch_stall
// All outputs are held at 0 while reset_n is low.
module rob_commit_ctrl #(
  parameter int ARF_SIZE  = rob_pkg::ARF_SIZE,
  parameter int ARF_WIDTH = rob_pkg::ARF_WIDTH,
  parameter int PRF_WIDTH = rob_pkg::PRF_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 rob_head_ready,
  input  logic                 rob_head_has_dest,
  input  logic [ARF_WIDTH-1:0] rob_head_arf,
  input  logic [PRF_WIDTH-1:0] rob_head_prf,
  input  logic                 rob_head_is_store,
  input  logic                 rob_head_is_branch,
  input  logic                 rob_head_mispredict,
  input  logic [63:0]          rob_head_npc,
  input  logic                 st_commit_ready,
  output logic                 rob_retire,
  output logic                 free_valid,
  output logic [PRF_WIDTH-1:0] free_prf,
  output logic                 st_commit_valid,
  output logic                 squash,
  output logic [63:0]          redirect_pc,
  output logic                 restore_valid,
  output logic [ARF_WIDTH-1:0] restore_arf,
  output logic [PRF_WIDTH-1:0] restore_prf,
  output logic                 dispatch_stall
`ifdef COMMIT_STATS_EN
  ,
  output logic [31:0]          retired_count,
  output logic [31:0]          mispredict_count
`endif
);

  import rob_pkg::*;

  commit_state_t        state, state_next;
  logic [ARF_WIDTH-1:0] count, count_next;
  logic                 rrat_we;
  logic [PRF_WIDTH-1:0] old_prf, replay_prf;

  rrat_table #(
    .DEPTH  (ARF_SIZE),
    .IDX_W  (ARF_WIDTH),
    .DATA_W (PRF_WIDTH)
  ) u_rrat (
    .clock     (clock),
    .reset_n   (reset_n),
    .rd_a_idx  (rob_head_arf),
    .rd_a_data (old_prf),
    .rd_b_idx  (count),
    .rd_b_data (replay_prf),
    .we        (rrat_we),
    .wr_idx    (rob_head_arf),
    .wr_data   (rob_head_prf)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of the others.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // NOTE: every output and next-state variable gets a default before the
  // case statement so no path leaves one unassigned (no latches).
  always_comb begin
    state_next      = state;
    count_next      = count;
    rrat_we         = 1'b0;
    rob_retire      = 1'b0;
    free_valid      = 1'b0;
    free_prf        = '0;
    st_commit_valid = 1'b0;
    squash          = 1'b0;
    redirect_pc     = '0;
    restore_valid   = 1'b0;
    restore_arf     = '0;
    restore_prf     = '0;
    dispatch_stall  = 1'b0;

    // Outputs are combinational from the head, so gate them with reset too.
    if (reset_n) begin
      unique case (state)
        RUN: begin
          if (rob_head_ready) begin
            if (rob_head_is_store) begin
              // Valid is independent of the LSQ handshake; dest is ignored.
              st_commit_valid = 1'b1;
              rob_retire      = st_commit_ready;
            end else begin
              rob_retire = 1'b1;
              if (rob_head_has_dest) begin
                free_valid = 1'b1;
                free_prf   = old_prf;
                rrat_we    = 1'b1;
              end
              // A mispredict flag on a non-branch is a plain retire.
              if (rob_head_is_branch && rob_head_mispredict) begin
                squash      = 1'b1;
                redirect_pc = rob_head_npc;
                state_next  = RESTORE;
                count_next  = '0;
              end
            end
          end
        end

        RESTORE: begin
          restore_valid  = 1'b1;
          restore_arf    = count;
          restore_prf    = replay_prf;
          dispatch_stall = 1'b1;
          if (count == ARF_WIDTH'(ARF_SIZE - 1)) begin
            state_next = RUN;
            count_next = '0;
          end else begin
            count_next = count + 1'b1;
          end
        end

        default: state_next = RUN;
      endcase
    end
  end

`ifdef COMMIT_STATS_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      retired_count    <= '0;
      mispredict_count <= '0;
    end else begin
      retired_count    <= retired_count + 32'(rob_retire);
      mispredict_count <= mispredict_count + 32'(squash);
    end
  end
`endif

endmodule : rob_commit_ctrl
